// File: rtl/isp_ccm.sv
// Colour correction matrix: 3x3 signed fixed-point RGB transform, 3-cycle latency.
// Define ISP_CCM_SHADOW_EN to latch ccm_coef/ccm_en only on the in_vsync rising edge.
module isp_ccm #(
  parameter int BITS      = 8,
  parameter int COEF_BITS = 12,
  parameter int FRAC_BITS = 8
) (
  input  logic                   pclk,
  input  logic                   rst_n,
  input  logic                   in_href,
  input  logic                   in_vsync,
  input  logic [BITS-1:0]        in_r,
  input  logic [BITS-1:0]        in_g,
  input  logic [BITS-1:0]        in_b,
  input  logic                   ccm_en,
  input  logic [9*COEF_BITS-1:0] ccm_coef,
  output logic                   out_href,
  output logic                   out_vsync,
  output logic [BITS-1:0]        out_r,
  output logic [BITS-1:0]        out_g,
  output logic [BITS-1:0]        out_b
);

  localparam int PW = BITS + COEF_BITS + 1;
  localparam int SW = BITS + COEF_BITS + 3;
  localparam logic signed [SW-1:0] RND = SW'(2 ** (FRAC_BITS - 1));

  logic [2:0] href_d;
  logic [2:0] vsync_d;

  logic [9*COEF_BITS-1:0] act_coef;
  logic                   act_en;

`ifdef ISP_CCM_SHADOW_EN
  localparam logic [COEF_BITS-1:0] ONE  = COEF_BITS'(2 ** FRAC_BITS);
  localparam logic [COEF_BITS-1:0] ZERO = '0;
  localparam logic [9*COEF_BITS-1:0] IDENT =
    {ONE, ZERO, ZERO, ZERO, ONE, ZERO, ZERO, ZERO, ONE};

  logic                   vsync_rise;
  logic [9*COEF_BITS-1:0] shd_coef;
  logic                   shd_en;

  assign vsync_rise = in_vsync & ~vsync_d[0];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      shd_coef <= IDENT;
      shd_en   <= 1'b1;
    end else if (vsync_rise) begin
      shd_coef <= ccm_coef;
      shd_en   <= ccm_en;
    end
  end

  // The pixel on the update cycle already uses the new set.
  assign act_coef = vsync_rise ? ccm_coef : shd_coef;
  assign act_en   = vsync_rise ? ccm_en   : shd_en;
`else
  assign act_coef = ccm_coef;
  assign act_en   = ccm_en;
`endif

  logic signed [COEF_BITS-1:0] m      [9];
  logic signed [BITS:0]        px     [3];
  logic signed [PW-1:0]        prod_c [9];

  always_comb begin
    px[0] = $signed({1'b0, in_r});
    px[1] = $signed({1'b0, in_g});
    px[2] = $signed({1'b0, in_b});
    for (int i = 0; i < 9; i++) begin
      m[i]      = $signed(act_coef[i*COEF_BITS +: COEF_BITS]);
      prod_c[i] = PW'(m[i]) * PW'(px[i % 3]);
    end
  end

  logic signed [PW-1:0]       prod_q [9];
  logic                       en1;
  logic [2:0][BITS-1:0]       byp1;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      en1  <= 1'b0;
      byp1 <= '0;
    end else begin
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_c[i];
      en1  <= act_en;
      byp1 <= {in_b, in_g, in_r};
    end
  end

  logic signed [SW-1:0] sum_c [3];
  logic signed [SW-1:0] sum_q [3];
  logic                 en2;
  logic [2:0][BITS-1:0] byp2;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sum_c[c] = SW'(prod_q[3*c]) + SW'(prod_q[3*c+1]) + SW'(prod_q[3*c+2]) + RND;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) sum_q[c] <= '0;
      en2  <= 1'b0;
      byp2 <= '0;
    end else begin
      for (int c = 0; c < 3; c++) sum_q[c] <= sum_c[c];
      en2  <= en1;
      byp2 <= byp1;
    end
  end

  logic signed [SW-1:0] sh  [3];
  logic [BITS-1:0]      res [3];

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sh[c] = sum_q[c] >>> FRAC_BITS;
      if (!en2)
        res[c] = byp2[c];
      else if (sh[c][SW-1])
        res[c] = '0;
      else if (|sh[c][SW-2:BITS])
        res[c] = '1;
      else
        res[c] = sh[c][BITS-1:0];
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_d  <= '0;
      vsync_d <= '0;
      out_r   <= '0;
      out_g   <= '0;
      out_b   <= '0;
    end else begin
      href_d  <= {href_d[1:0], in_href};
      vsync_d <= {vsync_d[1:0], in_vsync};
      // Blank outside the line so downstream never sees stale pixels.
      out_r   <= href_d[1] ? res[0] : '0;
      out_g   <= href_d[1] ? res[1] : '0;
      out_b   <= href_d[1] ? res[2] : '0;
    end
  end

  assign out_href  = href_d[2];
  assign out_vsync = vsync_d[2];

endmodule

// File: tb/tb_isp_ccm.sv
// Bench for isp_ccm: directed and random pixels against an integer-arithmetic reference.
module tb_isp_ccm;

  localparam int BITS = 8;
  localparam int CB   = 12;
  localparam int FB   = 8;

  logic              pclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_href = 1'b0, in_vsync = 1'b0;
  logic [BITS-1:0]   in_r = '0, in_g = '0, in_b = '0;
  logic              ccm_en = 1'b1;
  logic [9*CB-1:0]   ccm_coef = '0;
  logic              out_href, out_vsync;
  logic [BITS-1:0]   out_r, out_g, out_b;

  isp_ccm #(.BITS(BITS), .COEF_BITS(CB), .FRAC_BITS(FB)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .in_href(in_href), .in_vsync(in_vsync),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .ccm_en(ccm_en), .ccm_coef(ccm_coef),
    .out_href(out_href), .out_vsync(out_vsync),
    .out_r(out_r), .out_g(out_g), .out_b(out_b)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic       href;
    logic       vsync;
    logic [7:0] r, g, b;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   tb_m[9];
  logic tb_en;
  exp_t pipe[3];
`ifdef ISP_CCM_SHADOW_EN
  int   act_m[9];
  logic act_en;
  logic vs_prev;
`endif

  function automatic logic [7:0] ccm_ch(input int a0, a1, a2, input int r, g, b);
    int s;
    s = a0 * r + a1 * g + a2 * b + (1 << (FB - 1));
    s = s >>> FB;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  function automatic int rand_coef();
    int v;
    v = int'($urandom_range(0, 4095));
    if (v >= 2048) v = v - 4096;
    return v;
  endfunction

  task automatic set_ident();
    tb_m = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
    tb_en = 1'b1;
  endtask

  task automatic set_swap();
    tb_m = '{0, 0, 256, 0, 256, 0, 256, 0, 0};
    tb_en = 1'b1;
  endtask

  task automatic model_reset();
    exp_t z;
    z = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 3; i++) pipe[i] = z;
`ifdef ISP_CCM_SHADOW_EN
    act_m   = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
    act_en  = 1'b1;
    vs_prev = 1'b0;
`endif
  endtask

  task automatic check(input string tag);
    checks++;
    assert (out_href === pipe[2].href && out_vsync === pipe[2].vsync)
    else begin
      errors++;
      $error("FAIL %s framing: got href=%b vsync=%b, want href=%b vsync=%b",
             tag, out_href, out_vsync, pipe[2].href, pipe[2].vsync);
    end
    checks++;
    assert ({out_r, out_g, out_b} === {pipe[2].r, pipe[2].g, pipe[2].b})
    else begin
      errors++;
      $error("FAIL %s rgb: got (%0d,%0d,%0d), want (%0d,%0d,%0d)",
             tag, out_r, out_g, out_b, pipe[2].r, pipe[2].g, pipe[2].b);
    end
  endtask

  task automatic step(input string tag, input logic href, input logic vsync,
                      input int r, input int g, input int b);
    exp_t e;
    int   m[9];
    logic en;
    in_href  = href;
    in_vsync = vsync;
    in_r     = 8'(r);
    in_g     = 8'(g);
    in_b     = 8'(b);
    ccm_en   = tb_en;
    for (int i = 0; i < 9; i++) ccm_coef[i*CB +: CB] = tb_m[i][CB-1:0];
`ifdef ISP_CCM_SHADOW_EN
    if (rst_n && vsync && !vs_prev) begin
      act_m  = tb_m;
      act_en = tb_en;
    end
    m  = act_m;
    en = act_en;
`else
    m  = tb_m;
    en = tb_en;
`endif
    e.href  = href;
    e.vsync = vsync;
    if (en) begin
      e.r = ccm_ch(m[0], m[1], m[2], r, g, b);
      e.g = ccm_ch(m[3], m[4], m[5], r, g, b);
      e.b = ccm_ch(m[6], m[7], m[8], r, g, b);
    end else begin
      e.r = 8'(r);
      e.g = 8'(g);
      e.b = 8'(b);
    end
    if (!href) begin
      e.r = 8'd0;
      e.g = 8'd0;
      e.b = 8'd0;
    end
    if (!rst_n) e = '{1'b0, 1'b0, 8'd0, 8'd0, 8'd0};
    @(posedge pclk);
`ifdef ISP_CCM_SHADOW_EN
    if (rst_n) vs_prev = vsync;
`endif
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
    #1 check(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic new_frame();
    step("vblank", 1'b0, 1'b1, 0, 0, 0);
    step("vblank", 1'b0, 1'b1, 0, 0, 0);
    idle("vblank", 2);
  endtask

  initial begin
    model_reset();
    set_ident();

    // Power-on reset state
    #12;
    checks++;
    assert ({out_href, out_vsync, out_r, out_g, out_b} === 26'd0)
    else begin
      errors++;
      $error("FAIL reset_state: got %h, want 0", {out_href, out_vsync, out_r, out_g, out_b});
    end
    step("in_reset", 1'b1, 1'b0, 1, 2, 3);
    rst_n = 1'b1;

    // Identity
    new_frame();
    step("identity", 1'b1, 1'b0, 100, 150, 200);
    idle("identity_tail", 4);

    // Saturation high and low
    set_ident();
    tb_m[0] = 512;
    tb_m[4] = -256;
    new_frame();
    step("saturate", 1'b1, 1'b0, 200, 50, 77);
    step("saturate", 1'b1, 1'b0, 255, 255, 0);
    idle("saturate_tail", 3);

    // Rounding half up
    tb_m = '{384, 0, 0, 0, 128, 0, 0, 0, 256};
    new_frame();
    step("round", 1'b1, 1'b0, 3, 1, 9);
    step("round", 1'b1, 1'b0, 1, 3, 0);
    idle("round_tail", 3);

    // Bypass with an arbitrary matrix
    for (int i = 0; i < 9; i++) tb_m[i] = rand_coef();
    tb_en = 1'b0;
    new_frame();
    step("bypass", 1'b1, 1'b0, 10, 20, 30);
    step("bypass", 1'b1, 1'b0, 250, 0, 128);
    idle("bypass_tail", 4);

    // Mid-frame R/B swap, then frame boundary
    set_ident();
    new_frame();
    step("pre_swap", 1'b1, 1'b0, 10, 20, 30);
    step("pre_swap", 1'b1, 1'b0, 10, 20, 30);
    set_swap();
    for (int i = 0; i < 4; i++) step("mid_swap", 1'b1, 1'b0, 10, 20, 30);
    idle("mid_swap_tail", 3);
    new_frame();
    for (int i = 0; i < 3; i++) step("post_swap", 1'b1, 1'b0, 10, 20, 30);
    idle("post_swap_tail", 3);

    // Random frames, including the most negative coefficient
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 9; i++) tb_m[i] = rand_coef();
      if (f == 0) tb_m[0] = -2048;
      if (f == 1) tb_m[4] = -2048;
      tb_en = ($urandom_range(0, 3) != 0);
      new_frame();
      for (int p = 0; p < 24; p++) begin
        if (f == 2 && p == 10) begin
          for (int i = 0; i < 9; i++) tb_m[i] = rand_coef();
          tb_en = ~tb_en;
        end
        step("random", ($urandom_range(0, 4) != 0), 1'b0,
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)));
      end
      idle("random_tail", 3);
    end

    // Reset in the middle of a line
    set_swap();
    new_frame();
    step("pre_reset", 1'b1, 1'b0, 10, 20, 30);
    step("pre_reset", 1'b1, 1'b0, 40, 50, 60);
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({out_href, out_vsync, out_r, out_g, out_b} === 26'd0)
    else begin
      errors++;
      $error("FAIL mid_reset: got %h, want 0", {out_href, out_vsync, out_r, out_g, out_b});
    end
    model_reset();
    step("held_reset", 1'b1, 1'b0, 70, 80, 90);
    step("held_reset", 1'b1, 1'b0, 70, 80, 90);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_reset", 1'b1, 1'b0, 10, 20, 30);
    idle("post_reset_tail", 3);
    new_frame();
    for (int i = 0; i < 3; i++) step("post_reset_frame", 1'b1, 1'b0, 10, 20, 30);
    idle("post_reset_frame_tail", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
